// File: rtl/wb_reg_file.sv
// MEM/WB pipeline register plus the 32-entry register file, with two
// combinational ID read ports that forward the pending WB write.
module wb_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en_from_mem,
  input  logic [ADDR_W-1:0] reg_write_addr_from_mem,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic              stall,
  input  logic              flush,
  input  logic              read_en_1,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic              read_en_2,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] data_1_from_reg,
  output logic [DATA_W-1:0] data_2_from_reg,
  output logic              reg_write_en_from_wb,
  output logic [ADDR_W-1:0] reg_write_addr_from_wb,
  output logic [DATA_W-1:0] data_from_wb
);

  logic              wbEn_q,   wbEn_d;
  logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
  logic [DATA_W-1:0] wbData_q, wbData_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Flush beats stall: a flushed stage must not keep a held write alive.
  always_comb begin
    wbEn_d   = wbEn_q;
    wbAddr_d = wbAddr_q;
    wbData_d = wbData_q;
    if (flush) begin
      wbEn_d   = 1'b0;
      wbAddr_d = '0;
      wbData_d = '0;
    end else if (!stall) begin
      wbEn_d   = reg_write_en_from_mem;
      wbAddr_d = reg_write_addr_from_mem;
      wbData_d = data_from_mem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbEn_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
    end else begin
      wbEn_q   <= wbEn_d;
      wbAddr_q <= wbAddr_d;
      wbData_q <= wbData_d;
    end
  end

  // Commit uses the current WB contents, so it still lands on a flush edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wbEn_q && (wbAddr_q != '0)) begin
      regs_q[wbAddr_q] <= wbData_q;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic en, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] result;
    result = '0;
    if (en && (addr != '0)) begin
      if (wbEn_q && (wbAddr_q == addr)) begin
        result = wbData_q;
      end else begin
        result = regs_q[addr];
      end
    end
    return result;
  endfunction

  assign data_1_from_reg        = readPort(read_en_1, read_addr_1);
  assign data_2_from_reg        = readPort(read_en_2, read_addr_2);
  assign reg_write_en_from_wb   = wbEn_q;
  assign reg_write_addr_from_wb = wbAddr_q;
  assign data_from_wb           = wbData_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Bench for wb_reg_file: directed scenarios plus random traffic against an
// array-based model of the WB stage and register file.
module tb_wb_reg_file;

  logic        clk;
  logic        rst;
  logic        memEn;
  logic [4:0]  memAddr;
  logic [31:0] memData;
  logic        stall;
  logic        flush;
  logic        rdEn1;
  logic [4:0]  rdAddr1;
  logic        rdEn2;
  logic [4:0]  rdAddr2;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        wbEn;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;

  int checkCount;
  int passCount;

  // Reference state: what the WB stage holds and what each register contains.
  logic        mWbEn;
  logic [4:0]  mWbAddr;
  logic [31:0] mWbData;
  logic [31:0] mRegs [32];

  wb_reg_file dut (
    .clk                     (clk),
    .rst                     (rst),
    .reg_write_en_from_mem   (memEn),
    .reg_write_addr_from_mem (memAddr),
    .data_from_mem           (memData),
    .stall                   (stall),
    .flush                   (flush),
    .read_en_1               (rdEn1),
    .read_addr_1             (rdAddr1),
    .read_en_2               (rdEn2),
    .read_addr_2             (rdAddr2),
    .data_1_from_reg         (data1),
    .data_2_from_reg         (data2),
    .reg_write_en_from_wb    (wbEn),
    .reg_write_addr_from_wb  (wbAddr),
    .data_from_wb            (wbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic [31:0] modelRead(input logic en, input logic [4:0] addr);
    if (!en || addr == 5'd0) return 32'd0;
    if (mWbEn && mWbAddr == addr) return mWbData;
    return mRegs[addr];
  endfunction

  task automatic modelReset();
    mWbEn   = 1'b0;
    mWbAddr = 5'd0;
    mWbData = 32'd0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic st, input logic fl,
                               input logic r1e, input logic [4:0] r1a,
                               input logic r2e, input logic [4:0] r2a);
    memEn   = we;
    memAddr = wa;
    memData = wd;
    stall   = st;
    flush   = fl;
    rdEn1   = r1e;
    rdAddr1 = r1a;
    rdEn2   = r2e;
    rdAddr2 = r2a;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".wb_en"},   {31'd0, wbEn},   {31'd0, mWbEn});
    checkOutput({tag, ".wb_addr"}, {27'd0, wbAddr}, {27'd0, mWbAddr});
    checkOutput({tag, ".wb_data"}, wbData,          mWbData);
    checkOutput({tag, ".port1"},   data1,           modelRead(rdEn1, rdAddr1));
    checkOutput({tag, ".port2"},   data2,           modelRead(rdEn2, rdAddr2));
  endtask

  // Advance one rising edge, updating the model with the inputs seen there.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (mWbEn && mWbAddr != 5'd0) mRegs[mWbAddr] = mWbData;
      if (flush) begin
        mWbEn   = 1'b0;
        mWbAddr = 5'd0;
        mWbData = 32'd0;
      end else if (!stall) begin
        mWbEn   = memEn;
        mWbAddr = memAddr;
        mWbData = memData;
      end
    end
    #1;
  endtask

  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic st, input logic fl,
                       input logic r1e, input logic [4:0] r1a,
                       input logic r2e, input logic [4:0] r2a, input string tag);
    applyStimulus(we, wa, wd, st, fl, r1e, r1a, r2e, r2a);
    #1;
    compareAll(tag);
    tick();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    modelReset();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2);
    #3;
    compareAll("reset");
    #9 rst = 1'b0;

    // Asynchronous reset in the middle of a cycle after r5 is written.
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, "r5_w");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    checkOutput("r5_bypass", data1, 32'h1234);
    tick();
    #1;
    checkOutput("r5_array", data1, 32'h1234);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst.port1", data1, 32'd0);
    checkOutput("async_rst.port2", data2, 32'd0);
    compareAll("async_rst");
    #1 rst = 1'b0;
    tick();
    #1;
    checkOutput("r5_after_rst", data1, 32'd0);

    // Basic write with bypass then array read.
    cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3, "r3_w");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    checkOutput("r3_wb_en", {31'd0, wbEn}, 32'd1);
    checkOutput("r3_wb_addr", {27'd0, wbAddr}, 32'd3);
    checkOutput("r3_wb_data", wbData, 32'hDEADBEEF);
    checkOutput("r3_bypass", data1, 32'hDEADBEEF);
    tick();
    #1;
    checkOutput("r3_array", data2, 32'hDEADBEEF);
    tick();

    // Register 0 never holds a value.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, "r0_w");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
      #1;
      checkOutput("r0_port1", data1, 32'd0);
      checkOutput("r0_port2", data2, 32'd0);
      tick();
    end

    // Stall holds r7 in WB; r8 behind it never lands; flush+stall empties WB.
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "r7_w");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd8, 32'h11111111, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd8);
      #1;
      checkOutput("stall_wb_addr", {27'd0, wbAddr}, 32'd7);
      checkOutput("stall_r8", data2, 32'd0);
      compareAll("stall");
      tick();
    end
    cycle(1'b1, 5'd8, 32'h11111111, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd8, "flush");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd8);
    #1;
    checkOutput("flush_wb_en", {31'd0, wbEn}, 32'd0);
    checkOutput("flush_r7", data1, 32'hA5A5A5A5);
    checkOutput("flush_r8", data2, 32'd0);
    tick();

    // Read enables and dual-port reads of the same register.
    cycle(1'b1, 5'd9,  32'h55, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "r9_w");
    cycle(1'b1, 5'd10, 32'h66, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "r10_w");
    cycle(1'b0, 5'd0,  32'd0,  1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, "idle");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd10);
    #1;
    checkOutput("en_port1", data1, 32'h55);
    checkOutput("en_port2_off", data2, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9);
    #1;
    checkOutput("dual_port1", data1, 32'h55);
    checkOutput("dual_port2", data2, 32'h55);
    tick();

    // Back-to-back writes to the same register.
    cycle(1'b1, 5'd4, 32'd1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4, "r4_w1");
    applyStimulus(1'b1, 5'd4, 32'd2, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);
    #1;
    checkOutput("b2b_first", data1, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);
    #1;
    checkOutput("b2b_second", data1, 32'd2);
    tick();
    #1;
    checkOutput("b2b_array", data2, 32'd2);
    tick();

    // Random traffic over a narrow address range to provoke bypass hits.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
